// File: rtl/software_adaptor_gen.sv
// Request/response adaptor: collects a header plus KEY_WORDS key words, waits (with
// timeout) for the engine result, then streams it back as RSP_WORDS words.
module software_adaptor_gen #(
  parameter int PKT_S     = 32,
  parameter int KEY_WORDS = 2,
  parameter int RSP_WORDS = 4,
  parameter int DT_S      = 3,
  parameter int TO_S      = 8,
  localparam int KH_S     = PKT_S * KEY_WORDS,
  localparam int D_S      = PKT_S * RSP_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_S-1:0] data_in,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [PKT_S-1:0] data_out,
  output logic             rsp_valid,
  input  logic             rd_ready,
  output logic             rsp_last,
  input  logic [D_S-1:0]   priv_data,
  input  logic             priv_valid,
  output logic [KH_S-1:0]  key_hash,
  output logic [DT_S-1:0]  req_type,
  output logic             key_en,
  output logic             busy,
  output logic             err
);

  localparam int KI_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int RI_W = (RSP_WORDS > 1) ? $clog2(RSP_WORDS) : 1;
  localparam logic [KI_W-1:0] K_LAST = KI_W'(KEY_WORDS - 1);
  localparam logic [RI_W-1:0] R_LAST = RI_W'(RSP_WORDS - 1);
  // Timeout fires on the edge where the counter would reach 2^TO_S-1.
  localparam logic [TO_S-1:0] TO_LIM = TO_S'((2 ** TO_S) - 2);

  typedef enum logic [1:0] {IDLE, KEY, WAIT, RSP} state_t;

  state_t          state, state_n;
  logic [KI_W-1:0] k;
  logic [RI_W-1:0] r;
  logic [TO_S-1:0] cnt;
  logic [D_S-1:0]  rsp_buf;
  logic            req_hs, rsp_hs, key_last, rsp_at_last, to_hit;

  assign req_ready   = (state == IDLE) || (state == KEY);
  assign rsp_valid   = (state == RSP);
  assign busy        = (state != IDLE);
  assign req_hs      = req_valid & req_ready;
  assign rsp_hs      = rsp_valid & rd_ready;
  assign key_last    = (k == K_LAST);
  assign rsp_at_last = (r == R_LAST);
  assign to_hit      = (cnt == TO_LIM);
  assign rsp_last    = rsp_valid & rsp_at_last;

  always_comb begin
    data_out = '0;
    if (state == RSP) begin
      for (int unsigned i = 0; i < RSP_WORDS; i++) begin
        if (r == RI_W'(i)) data_out = rsp_buf[i*PKT_S +: PKT_S];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_hs) state_n = KEY;
      KEY:  if (req_hs && key_last) state_n = WAIT;
      WAIT: begin
        if (priv_valid)  state_n = RSP;
        else if (to_hit) state_n = IDLE;
      end
      RSP:  if (rsp_hs && rsp_at_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      k        <= '0;
      r        <= '0;
      cnt      <= '0;
      rsp_buf  <= '0;
      key_hash <= '0;
      req_type <= '0;
      key_en   <= 1'b0;
      err      <= 1'b0;
    end else begin
      key_en <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_hs) begin
            req_type <= data_in[DT_S-1:0];
            k        <= '0;
          end
        end
        KEY: begin
          if (req_hs) begin
            // First key word occupies the most-significant slice.
            for (int unsigned i = 0; i < KEY_WORDS; i++) begin
              if (k == KI_W'(i)) key_hash[(KEY_WORDS-1-i)*PKT_S +: PKT_S] <= data_in;
            end
            if (key_last) begin
              key_en <= 1'b1;
              k      <= '0;
              cnt    <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (priv_valid) begin
            rsp_buf <= priv_data;
            r       <= '0;
            cnt     <= '0;
          end else if (to_hit) begin
            err <= 1'b1;
            cnt <= '0;
          end
        end
        RSP: begin
          if (rsp_hs) r <= rsp_at_last ? '0 : r + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/software_adaptor_gen.md
# software_adaptor_gen

Parametrised request/response adaptor between a 32-bit-class software packet port and the private key/data engine. It accepts a header word plus a configurable number of key words with valid/ready back-pressure, and presents the assembled key hash and request type to the engine. It waits, with a timeout, for the engine's private data, then streams that data back as a configurable number of response words under a full valid/ready handshake. It supersedes the fixed 1-header/2-key/4-response adaptor.

## Interface
Parameters:
- PKT_S, 32, packet word width
- KEY_WORDS, 2, key words per request (>=1); KH_S = PKT_S*KEY_WORDS
- RSP_WORDS, 4, response words per request (>=1); D_S = PKT_S*RSP_WORDS
- DT_S, 3, request type width (<= PKT_S)
- TO_S, 8, timeout counter width; timeout = 2^TO_S-1 cycles

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- data_in  in  PKT_S  request word
- req_valid  in  1  request word valid
- req_ready  out  1  adaptor accepts request word
- data_out  out  PKT_S  response word
- rsp_valid  out  1  response word valid
- rd_ready  in  1  consumer accepts response word
- rsp_last  out  1  current response word is the final one
- priv_data  in  D_S  engine result
- priv_valid  in  1  engine result valid
- key_hash  out  KH_S  assembled key
- req_type  out  DT_S  request type from header
- key_en  out  1  one-cycle pulse, key_hash/req_type valid
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on engine timeout

## Operation
- States: IDLE, KEY, WAIT, RSP.
- All outputs are registered or decoded from registered state only. No combinational path runs from an input to an output.
- **IDLE**: req_ready=1.
  - A request handshake (req_valid & req_ready) captures req_type <= data_in[DT_S-1:0] and moves to KEY with key index k=0.
- **KEY**: req_ready=1.
  - Each handshake writes data_in into key_hash slice [(KEY_WORDS-1-k)*PKT_S +: PKT_S]. The first key word lands in the most-significant slice.
  - k increments on each handshake. The handshake at k=KEY_WORDS-1 moves to WAIT and registers key_en=1 for exactly one cycle.
- **WAIT**: req_ready=0; timeout counter cleared on entry and incremented each cycle.
  - priv_valid=1 captures priv_data into the response buffer and moves to RSP with response index r=0.
  - If the counter reaches 2^TO_S-1 with priv_valid=0: err pulses for one cycle, state returns to IDLE, and no response is sent.
  - priv_valid in the cycle the limit is reached wins: data is captured and there is no err.
- **RSP**: req_ready=0; rsp_valid=1; data_out = buffer[r*PKT_S +: PKT_S] (word 0 = bits PKT_S-1:0); rsp_last = (r==RSP_WORDS-1).
  - data_out and rsp_last stay stable while rd_ready=0.
  - A handshake (rsp_valid & rd_ready) increments r. The handshake at r=RSP_WORDS-1 returns to IDLE.
- data_out=0 whenever rsp_valid=0.
- key_hash and req_type hold their values until overwritten by the next request. The response buffer is only written in WAIT.
- Index counters are $clog2 wide, minimum 1 bit. They never exceed KEY_WORDS-1 or RSP_WORDS-1 and reset to 0 on each state entry.
- Words presented on the request side during WAIT/RSP are not accepted (req_ready=0) and are not dropped silently. The producer must hold them.

## Timing
- Reset (rst=0 sampled at an edge) applies from the following cycle:
  - state IDLE, counters 0
  - req_ready=1, rsp_valid=0, rsp_last=0, data_out=0
  - key_hash=0, req_type=0, key_en=0, busy=0, err=0
- Reset mid-operation aborts any request or response immediately, with no partial-response completion.
- Header accepted at edge t → KEY from t+1.
- Last key word accepted at edge t → key_en=1 and key_hash final during cycle t+1 only; WAIT from t+1.
- priv_valid sampled at edge t (in WAIT) → rsp_valid=1 with word 0 in cycle t+1.
- Response throughput: one word per cycle with rd_ready held high, so a full response takes RSP_WORDS cycles.
- Minimum request-to-request turnaround: 1 (header) + KEY_WORDS + 1 (WAIT) + RSP_WORDS cycles.
- Last response handshake at edge t → IDLE, req_ready=1 in cycle t+1. There is no back-to-back overlap with the next header.
- Timeout: err is asserted in the cycle after WAIT has been occupied for 2^TO_S-1 cycles without priv_valid.

## Test plan
- **Nominal, default params**: header 0x5, key words 0xAAAA_0001 then 0xBBBB_0002; priv_valid with priv_data=0x4444_4444_3333_3333_2222_2222_1111_1111; rd_ready=1.
  - key_hash=0xAAAA0001BBBB0002, req_type=5, single-cycle key_en.
  - data_out 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; rsp_last on the 4th word only.
- **Back-pressure**: drop req_valid between key words, and drop rd_ready for 3 cycles on response word 2.
  - Key still assembles correctly.
  - data_out holds 0x33333333 with rsp_valid=1 throughout the stall; no word is skipped or repeated.
- **Timeout, TO_S=3**: no priv_valid.
  - err pulses exactly 7 cycles after WAIT entry; back to IDLE; rsp_valid never rises.
  - priv_valid in cycle 7 instead: no err, response proceeds.
- **Reset mid-response**: rst=0 during response word 1.
  - Next cycle: rsp_valid=0, data_out=0, key_hash=0, busy=0.
  - A new request then completes normally.
- **Parameter sweep KEY_WORDS=1, RSP_WORDS=1**: header, one key word 0xDEADBEEF, priv_data=0x12345678.
  - key_hash=0xDEADBEEF.
  - Single response word 0x12345678 with rsp_last=1.
- **Request during WAIT/RSP**: hold req_valid=1 with 0x7 in those states.
  - req_ready stays 0.
  - The word is accepted as the next header in the first IDLE cycle, giving req_type=7.
